// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN result transmitter: TX sequencer states and
// frame geometry defaults.
package cnn_pkg;

    localparam int N_BITS_DEFAULT     = 676;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    // Bytes needed to carry one frame; the last byte may be partial.
    function automatic int bytes_per_frame(input int n_bits);
        return (n_bits + 7) / 8;
    endfunction

endpackage

// File: rtl/cnn_byte_fifo.sv
// Small byte FIFO with a combinational head; simultaneous push and pop both
// succeed even when full.
module cnn_byte_fifo
    import cnn_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

endmodule

// File: rtl/cnn_result_tx.sv
// Packs the CNN core's serial result bits LSB-first into bytes, buffers them
// and hands them one at a time to the UART transmitter.
module cnn_result_tx
    import cnn_pkg::*;
#(
    parameter int N_BITS     = N_BITS_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_vld,
    input  logic       din,
    output logic       din_rdy,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       bsy,
    output logic       frm_done
);

    localparam int         N_BYTES   = bytes_per_frame(N_BITS);
    localparam logic [9:0] LAST_BIT  = 10'(N_BITS - 1);
    localparam logic [7:0] LAST_BYTE = 8'(N_BYTES - 1);

    logic [2:0] pos_reg;
    logic [9:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [7:0] byte_next;
    logic       last_bit;
    logic       byte_full;
    logic       accept;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    tx_state_t  state_reg;
    tx_state_t  state_next;
    logic [7:0] tx_data_reg;
    logic [7:0] tx_byte_cnt_reg;
    logic       frm_done_reg;

    // A byte closes on its 8th bit or on the last bit of the frame.
    assign last_bit  = (bit_cnt_reg == LAST_BIT);
    assign byte_full = (pos_reg == 3'd7) || last_bit;
    assign din_rdy   = !(fifo_full && byte_full);
    assign accept    = din_vld && din_rdy;
    assign fifo_push = accept && byte_full;

    always_comb begin
        byte_next          = shift_reg;
        byte_next[pos_reg] = din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_reg     <= 3'd0;
            bit_cnt_reg <= 10'd0;
            shift_reg   <= 8'h00;
        end else if (accept) begin
            bit_cnt_reg <= last_bit ? 10'd0 : bit_cnt_reg + 10'd1;
            if (byte_full) begin
                pos_reg   <= 3'd0;
                shift_reg <= 8'h00;
            end else begin
                pos_reg   <= pos_reg + 3'd1;
                shift_reg <= byte_next;
            end
        end
    end

    cnn_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (byte_next),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= TX_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        trmt       = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = TX_LOAD;
                end
            end
            TX_LOAD: begin
                trmt       = 1'b1;
                state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done) begin
                    fifo_pop   = !fifo_empty;
                    state_next = fifo_empty ? TX_IDLE : TX_LOAD;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Byte count of the frame on the wire, so frm_done follows its last byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_reg     <= 8'h00;
            tx_byte_cnt_reg <= 8'd0;
            frm_done_reg    <= 1'b0;
        end else begin
            frm_done_reg <= 1'b0;
            if (fifo_pop) tx_data_reg <= fifo_dout;
            if (state_reg == TX_WAIT && tx_done) begin
                if (tx_byte_cnt_reg == LAST_BYTE) begin
                    tx_byte_cnt_reg <= 8'd0;
                    frm_done_reg    <= 1'b1;
                end else begin
                    tx_byte_cnt_reg <= tx_byte_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign tx_data  = tx_data_reg;
    assign frm_done = frm_done_reg;
    assign bsy      = (bit_cnt_reg != 10'd0) || !fifo_empty || (state_reg != TX_IDLE);

endmodule

// File: tb/tb_cnn_result_tx.sv
// Randomized bench for cnn_result_tx: a queue-based reference of expected bytes
// and frame ends, plus a behavioural UART responder.
module tb_cnn_result_tx;

    localparam int NB   = 676;
    localparam int FD   = 4;
    localparam int NBY  = (NB + 7) / 8;
    localparam int NB2  = 16;
    localparam int NBY2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, din_vld, din, din_rdy, trmt, tx_done, bsy, frm_done;
    logic [7:0] tx_data;
    logic       rst2, din_vld2, din2, din_rdy2, trmt2, tx_done2, bsy2, frm_done2;
    logic [7:0] tx_data2;

    cnn_result_tx #(.N_BITS(NB), .FIFO_DEPTH(FD)) u_dut (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .din_rdy(din_rdy),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .bsy(bsy), .frm_done(frm_done)
    );

    cnn_result_tx #(.N_BITS(NB2), .FIFO_DEPTH(FD)) u_dut16 (
        .clk(clk), .rst(rst2), .din_vld(din_vld2), .din(din2), .din_rdy(din_rdy2),
        .trmt(trmt2), .tx_data(tx_data2), .tx_done(tx_done2), .bsy(bsy2), .frm_done(frm_done2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: frame bit stream -> expected byte queue.
    logic [7:0] exp_q[$];
    int         m_cnt = 0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    int         acc_cyc = 0;

    task automatic model_bit(input logic b);
        m_byte[m_pos] = b;
        m_pos++;
        m_cnt++;
        if (m_pos == 8 || m_cnt == NB) begin
            exp_q.push_back(m_byte);
            m_byte = 8'h00;
            m_pos  = 0;
            if (m_cnt == NB) m_cnt = 0;
        end
    endtask

    // UART responder for the main instance.
    bit         busy = 0, exp_frm = 0, hold = 0, stray_req = 0;
    int         wait_cnt = 0, sent = 0, n_trmt = 0, n_frm = 0, trmt_cyc = -100;
    int         tx_delay = 10;
    logic [7:0] cur = 8'h00, last_tx = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            busy = 0; tx_done = 1'b0; exp_frm = 0; sent = 0;
        end else begin
            if (frm_done || exp_frm) begin
                chk("frm_done", frm_done, exp_frm);
                if (frm_done) n_frm++;
            end
            exp_frm = 0;
            tx_done = 1'b0;
            if (stray_req) begin
                tx_done   = 1'b1;
                stray_req = 0;
            end
            if (trmt) begin
                n_trmt++;
                trmt_cyc = cyc;
                last_tx  = tx_data;
                chk("trmt_single", busy, 0);
                if (exp_q.size() == 0) chk("trmt_unexpected", trmt, 0);
                else                   chk("tx_data", tx_data, exp_q.pop_front());
                $display("tx byte %0d data %02h", sent, tx_data);
                busy = 1; cur = tx_data; wait_cnt = tx_delay - 1;
            end else if (busy) begin
                if (wait_cnt > 0) wait_cnt--;
                else if (!hold) begin
                    chk("tx_hold", tx_data, cur);
                    tx_done = 1'b1;
                    busy    = 0;
                    sent++;
                    if (sent % NBY == 0) exp_frm = 1;
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        int n = 0;
        @(negedge clk);
        din_vld = 1'b1;
        din     = b;
        while (!din_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("din_rdy_timeout", din_rdy, 1);
        else begin
            model_bit(b);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1 din_vld = 1'b0;
    endtask

    task automatic send_frame(input bit ones, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_bit(ones ? 1'b1 : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy || bsy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 5000, 1);
        repeat (3) @(negedge clk);
    endtask

    // Second instance: 16-bit frames, back to back.
    logic [7:0] exp2_q[$];
    bit         busy2 = 0, exp_frm2 = 0, done2 = 0;
    int         wait2 = 0, sent2 = 0, n_frm2 = 0;
    logic [7:0] cur2 = 8'h00;

    always @(negedge clk) begin
        if (!rst2) begin
            if (frm_done2 || exp_frm2) begin
                chk("frm_done16", frm_done2, exp_frm2);
                if (frm_done2) n_frm2++;
            end
            exp_frm2 = 0;
            tx_done2 = 1'b0;
            if (trmt2) begin
                chk("trmt16_single", busy2, 0);
                if (exp2_q.size() == 0) chk("trmt16_unexpected", trmt2, 0);
                else                    chk("tx_data16", tx_data2, exp2_q.pop_front());
                $display("tx16 byte %0d data %02h", sent2, tx_data2);
                busy2 = 1; cur2 = tx_data2; wait2 = 2;
            end else if (busy2) begin
                if (wait2 > 0) wait2--;
                else begin
                    chk("tx16_hold", tx_data2, cur2);
                    tx_done2 = 1'b1;
                    busy2    = 0;
                    sent2++;
                    if (sent2 % NBY2 == 0) exp_frm2 = 1;
                end
            end
        end
    end

    initial begin
        logic [15:0] fr;
        int          n;
        rst2 = 1'b1; din_vld2 = 1'b0; din2 = 1'b0; tx_done2 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst2 = 1'b0;
        for (int f = 0; f < 3; f++) begin
            fr = 16'($urandom);
            exp2_q.push_back(fr[7:0]);
            exp2_q.push_back(fr[15:8]);
            for (int i = 0; i < NB2; i++) begin
                @(negedge clk);
                din_vld2 = 1'b1;
                din2     = fr[i];
                n = 0;
                while (!din_rdy2 && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 500) chk("din_rdy16_timeout", din_rdy2, 1);
                @(posedge clk);
                #1 din_vld2 = 1'b0;
            end
        end
        n = 0;
        while ((exp2_q.size() != 0 || busy2 || bsy2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("frames16", n_frm2, 3);
        done2 = 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d required < 500000", cyc);
        $fatal(1);
    end

    initial begin
        int         t0, f0, acc, stall;
        logic [7:0] pat;
        rst = 1'b1; din_vld = 1'b0; din = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trmt", trmt, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_bsy", bsy, 0);
        chk("rst_frm_done", frm_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_din_rdy", din_rdy, 1);

        // Single known byte, then the rest of that frame randomized.
        pat = 8'h0D;
        send_bit(pat[0]);
        chk("bsy_mid_frame", bsy, 1);
        for (int i = 1; i < 8; i++) send_bit(pat[i]);
        repeat (6) @(negedge clk);
        chk("first_byte", last_tx, 8'h0D);
        chk("push_to_trmt_latency", trmt_cyc - acc_cyc, 2);
        send_frame(0, NB - 8, 1);
        wait_drain();
        chk("frame1_trmt_count", n_trmt, NBY);
        chk("frame1_frm_count", n_frm, 1);
        chk("idle_bsy", bsy, 0);

        // All-ones frame: 84 x FF then a half-filled 0F.
        t0 = n_trmt; f0 = n_frm;
        send_frame(1, NB, 0);
        wait_drain();
        chk("ones_trmt_count", n_trmt - t0, NBY);
        chk("ones_last_byte", last_tx, 8'h0F);
        chk("ones_frm_count", n_frm - f0, 1);

        // tx_done while idle must be ignored.
        t0 = n_trmt;
        stray_req = 1;
        repeat (10) @(negedge clk);
        chk("stray_no_trmt", n_trmt, t0);
        chk("stray_bsy", bsy, 0);

        // Backpressure: UART stalled, stream until din_rdy stays low.
        hold = 1; acc = 0; stall = 0; f0 = n_frm;
        for (int i = 0; i < 300 && stall < 20; i++) begin
            @(negedge clk);
            din_vld = 1'b1;
            din     = 1'($urandom_range(0, 1));
            if (din_rdy) begin
                model_bit(din);
                acc++;
                stall = 0;
            end else stall++;
        end
        din_vld = 1'b0;
        chk("stall_bit_count", acc, (FD + 1) * 8 + 7);
        chk("stall_din_rdy", din_rdy, 0);
        hold = 0;
        send_frame(0, NB - acc, 1);
        wait_drain();
        chk("stall_frm_count", n_frm - f0, 1);

        // Reset while one byte is in flight and three are queued.
        hold = 1; t0 = n_trmt;
        send_frame(0, 32, 0);
        repeat (15) @(negedge clk);
        chk("pre_rst_in_flight", n_trmt - t0, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        m_cnt = 0; m_pos = 0; m_byte = 8'h00;
        @(negedge clk);
        chk("mid_rst_trmt", trmt, 0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_bsy", bsy, 0);
        chk("mid_rst_frm_done", frm_done, 0);
        hold = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        t0 = n_trmt;
        repeat (30) @(negedge clk);
        chk("post_rst_no_trmt", n_trmt, t0);
        chk("post_rst_din_rdy", din_rdy, 1);
        f0 = n_frm;
        send_frame(0, NB, 1);
        wait_drain();
        chk("post_rst_trmt_count", n_trmt - t0, NBY);
        chk("post_rst_frm_count", n_frm - f0, 1);

        for (int i = 0; i < 2000 && !done2; i++) @(negedge clk);
        chk("inst16_done", done2, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
